// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 Set-2 scan-code controller: parser states,
// prefix bytes, game-key scan codes, key indices and the scan-code lookup.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    localparam logic [7:0] BYTE_E0  = 8'hE0;
    localparam logic [7:0] BYTE_F0  = 8'hF0;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_SPACE = 8'h29;

    localparam int NUM_KEYS = 5;

    localparam logic [2:0] KEY_UP    = 3'd0;
    localparam logic [2:0] KEY_LEFT  = 3'd1;
    localparam logic [2:0] KEY_RIGHT = 3'd2;
    localparam logic [2:0] KEY_DOWN  = 3'd3;
    localparam logic [2:0] KEY_SPACE = 3'd4;

    typedef struct packed {
        logic       hit;
        logic [2:0] key;
    } key_lookup_t;

    // Arrow keys exist only behind E0 (the plain codes are the keypad);
    // space exists only without E0.
    function automatic key_lookup_t lookup_key(input logic [7:0] code, input logic ext);
        key_lookup_t res;
        res.hit = 1'b0;
        res.key = 3'd0;
        if (ext) begin
            case (code)
                SC_UP:    begin res.hit = 1'b1; res.key = KEY_UP;    end
                SC_LEFT:  begin res.hit = 1'b1; res.key = KEY_LEFT;  end
                SC_RIGHT: begin res.hit = 1'b1; res.key = KEY_RIGHT; end
                SC_DOWN:  begin res.hit = 1'b1; res.key = KEY_DOWN;  end
                default:  begin res.hit = 1'b0; res.key = 3'd0;      end
            endcase
        end else begin
            case (code)
                SC_SPACE: begin res.hit = 1'b1; res.key = KEY_SPACE; end
                default:  begin res.hit = 1'b0; res.key = 3'd0;      end
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/ps2_event_slot.sv
// Single-entry valid/ready holding register for key events, with a sticky
// overflow flag raised when an event arrives while the slot is still full.
module ps2_event_slot
    import ps2_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       push_i,
    input  logic [2:0] key_i,
    input  logic       make_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [2:0] key_o,
    output logic       make_o,
    output logic       overflow_o
);

    logic       valid_q, valid_d;
    logic [2:0] key_q,   key_d;
    logic       make_q,  make_d;
    logic       ovf_q,   ovf_d;

    // Load on push when empty or being drained; otherwise drop and flag overflow.
    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        make_d  = make_q;
        ovf_d   = ovf_q;
        if (push_i) begin
            if (!valid_q || ready_i) begin
                valid_d = 1'b1;
                key_d   = key_i;
                make_d  = make_i;
            end else begin
                ovf_d   = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            key_q   <= 3'd0;
            make_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            key_q   <= key_d;
            make_q  <= make_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o    = valid_q;
    assign key_o      = key_q;
    assign make_o     = make_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// PS/2 Set-2 scan-code sequencer: parses E0/F0 prefixes, tracks held state of
// five game keys, pulses key_press on makes and feeds a one-entry event slot.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of held
// keys and breaks of keys that are not held.
module ps2_scancode_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CNT_W          = 20
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [7:0]          received_data,
    input  logic                received_data_en,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [2:0]          evt_key,
    output logic                evt_make,
    output logic                evt_overflow
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic                timeout_s;
    logic                ext_s, brk_s, make_s, break_s, push_s;
    key_lookup_t         lk_s;
    logic [NUM_KEYS-1:0] key_oh_s;

    assign timeout_s = (cnt_q == TO_LAST);

    // Parser state register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next parser state: bytes steer the prefix states, a stale prefix times out.
    always_comb begin
        state_d = state_q;
        if (received_data_en) begin
            case (received_data)
                BYTE_E0: state_d = ST_EXT;
                BYTE_F0: state_d = (state_q == ST_EXT || state_q == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && timeout_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // Decode the strobed byte against the current prefix state into make/break of a key.
    always_comb begin
        ext_s   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        brk_s   = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        lk_s    = lookup_key(received_data, ext_s);
        make_s  = 1'b0;
        break_s = 1'b0;
        if (received_data_en && received_data != BYTE_E0 && received_data != BYTE_F0 && lk_s.hit) begin
            make_s  = !brk_s;
            break_s = brk_s;
        end else begin
            make_s  = 1'b0;
            break_s = 1'b0;
        end
    end

    // Prefix-to-follow-up counter: cleared by any byte, runs only while a prefix is pending.
    always_comb begin
        cnt_d = '0;
        if (received_data_en) begin
            cnt_d = '0;
        end else if (state_q != ST_IDLE && !timeout_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Held/press update and event request for an accepted make or break.
    always_comb begin
        key_oh_s = {{(NUM_KEYS-1){1'b0}}, 1'b1} << lk_s.key;
        held_d   = held_q;
        press_d  = '0;
        push_s   = 1'b0;
        if (make_s) begin
            held_d = held_q | key_oh_s;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if ((held_q & key_oh_s) == '0) begin
                press_d = key_oh_s;
                push_s  = 1'b1;
            end else begin
                press_d = '0;
                push_s  = 1'b0;
            end
`else
            press_d = key_oh_s;
            push_s  = 1'b1;
`endif
        end else if (break_s) begin
            held_d = held_q & ~key_oh_s;
`ifdef PS2_TYPEMATIC_FILTER_EN
            push_s = ((held_q & key_oh_s) != '0);
`else
            push_s = 1'b1;
`endif
        end else begin
            held_d = held_q;
        end
    end

    // Held flags and one-cycle press pulses.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            held_q  <= '0;
            press_q <= '0;
        end else begin
            held_q  <= held_d;
            press_q <= press_d;
        end
    end

    assign key_held  = held_q;
    assign key_press = press_q;

    ps2_event_slot u_slot (
        .clk_i      (CLOCK_50),
        .reset_i    (reset),
        .push_i     (push_s),
        .key_i      (lk_s.key),
        .make_i     (make_s),
        .ready_i    (evt_ready),
        .valid_o    (evt_valid),
        .key_o      (evt_key),
        .make_o     (evt_make),
        .overflow_o (evt_overflow)
    );

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Self-checking bench for ps2_scancode_ctrl: directed scenarios with literal
// expectations plus a randomized byte stream compared every cycle against a
// prefix-flag model of the scan-code protocol.
module tb_ps2_scancode_ctrl;

    localparam int T = 50;

`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       en;
    logic       ready;
    logic [4:0] held, press;
    logic       evalid, emake, eovf;
    logic [2:0] ekey;

    always #5 clk = ~clk;

    ps2_scancode_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .CLOCK_50         (clk),
        .reset            (reset),
        .received_data    (data),
        .received_data_en (en),
        .key_held         (held),
        .key_press        (press),
        .evt_valid        (evalid),
        .evt_ready        (ready),
        .evt_key          (ekey),
        .evt_make         (emake),
        .evt_overflow     (eovf)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [4:0] held;
        logic [4:0] press;
        logic       valid;
        logic [2:0] key;
        logic       make;
        logic       ovf;
        logic       ext;   // E0 seen, awaiting follow-up
        logic       brk;   // F0 seen, awaiting follow-up
    } mstate_t;

    mstate_t m = '0;
    int      cyc = 0;
    int      m_last = 0;
    bit      chk_en = 1'b0;

    function automatic int key_of(input logic [7:0] b, input logic ext);
        if (ext) begin
            if (b == 8'h75) return 0;
            if (b == 8'h6B) return 1;
            if (b == 8'h74) return 2;
            if (b == 8'h72) return 3;
            return -1;
        end
        if (b == 8'h29) return 4;
        return -1;
    endfunction

    function automatic mstate_t step(input mstate_t s, input logic e, input logic [7:0] b,
                                     input logic rdy, input logic stale);
        mstate_t n = s;
        logic ev = 1'b0;
        logic mk = 1'b0;
        int   idx;
        n.press = 5'b00000;
        if (s.valid && rdy) n.valid = 1'b0;
        if (e) begin
            if (stale) begin
                n.ext = 1'b0;
                n.brk = 1'b0;
            end
            if (b == 8'hE0) begin
                n.ext = 1'b1;
                n.brk = 1'b0;
            end else if (b == 8'hF0) begin
                n.brk = 1'b1;
            end else begin
                idx = key_of(b, n.ext);
                if (idx >= 0) begin
                    if (!n.brk) begin
                        mk = 1'b1;
                        if (!(FILT && s.held[idx])) begin
                            n.press[idx] = 1'b1;
                            ev = 1'b1;
                        end
                        n.held[idx] = 1'b1;
                    end else begin
                        if (!FILT || s.held[idx]) ev = 1'b1;
                        n.held[idx] = 1'b0;
                    end
                end
                n.ext = 1'b0;
                n.brk = 1'b0;
                if (ev) begin
                    if (!s.valid || rdy) begin
                        n.valid = 1'b1;
                        n.key   = 3'(idx);
                        n.make  = mk;
                    end else begin
                        n.ovf = 1'b1;
                    end
                end
            end
        end
        return n;
    endfunction

    // Model advances on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m <= '0;
        end else begin
            m <= step(m, en, data, ready, (cyc - m_last) > T);
            if (en) m_last <= cyc;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("held",  {27'd0, held},  {27'd0, m.held});
            chk("press", {27'd0, press}, {27'd0, m.press});
            chk("valid", {31'd0, evalid}, {31'd0, m.valid});
            chk("ovf",   {31'd0, eovf},  {31'd0, m.ovf});
            if (m.valid) begin
                chk("evt_key",  {29'd0, ekey},  {29'd0, m.key});
                chk("evt_make", {31'd0, emake}, {31'd0, m.make});
            end
        end
    end

    int pulse_cnt = 0;
    int ev_cnt = 0;
    // Counts up-key press pulses and accepted up-make events for the repeat test.
    always @(negedge clk) begin
        if (press[0]) pulse_cnt <= pulse_cnt + 1;
        if (evalid && ready && ekey == 3'd0 && emake) ev_cnt <= ev_cnt + 1;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #2;
        data = b;
        en   = 1'b1;
        @(posedge clk);
        #2;
        en   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [7:0] pick;

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        data  = 8'h00;
        ready = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;
        idle(2);
        chk("rst_held", {27'd0, held}, 32'd0);
        chk("rst_valid", {31'd0, evalid}, 32'd0);
        reset = 1'b0;

        // up make then break
        send(8'hE0); send(8'h75);
        chk("up_make_held", {27'd0, held}, 32'h01);
        chk("up_make_press", {27'd0, press}, 32'h01);
        chk("up_make_evt", {28'd0, evalid, ekey}, 32'h8);
        chk("up_make_flag", {31'd0, emake}, 32'd1);
        idle(1);
        chk("up_press_gone", {27'd0, press}, 32'h00);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_brk_held", {27'd0, held}, 32'h00);
        chk("up_brk_evt", {28'd0, evalid, ekey}, 32'h8);
        chk("up_brk_flag", {31'd0, emake}, 32'd0);

        // keypad 8 is unmapped
        send(8'h75);
        chk("keypad_held", {27'd0, held}, 32'h00);
        chk("keypad_valid", {31'd0, evalid}, 32'd0);

        // space
        send(8'h29);
        chk("space_held", {27'd0, held}, 32'h10);
        chk("space_press", {27'd0, press}, 32'h10);
        send(8'hF0); send(8'h29);
        chk("space_rel", {27'd0, held}, 32'h00);

        // prefix timeout boundary: gap of T still extended, T+1 and beyond not
        send(8'hE0); idle(T - 2); send(8'h75);
        chk("gap_T_held", {27'd0, held}, 32'h01);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); idle(T - 1); send(8'h75);
        chk("gap_T1_held", {27'd0, held}, 32'h00);
        send(8'hE0); idle(T + 20); send(8'h75);
        chk("gap_long_held", {27'd0, held}, 32'h00);

        // overflow: consumer stalled
        ready = 1'b0;
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'h6B);
        chk("ovf_held", {27'd0, held}, 32'h03);
        chk("ovf_evt", {28'd0, evalid, ekey}, 32'h8);
        chk("ovf_flag", {31'd0, eovf}, 32'd1);
        ready = 1'b1;
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h6B);
        chk("ovf_sticky", {31'd0, eovf}, 32'd1);

        // typematic repeat
        idle(2);
        pulse_cnt = 0;
        ev_cnt = 0;
        repeat (3) begin
            send(8'hE0); send(8'h75);
        end
        idle(3);
        chk("rep_pulses", pulse_cnt, FILT ? 32'd1 : 32'd3);
        chk("rep_events", ev_cnt, FILT ? 32'd1 : 32'd3);
        send(8'hE0); send(8'hF0); send(8'h75);

        // reset discards a pending prefix
        send(8'hE0); send(8'hF0);
        reset = 1'b1;
        idle(1);
        chk("rst_mid_all", {22'd0, held, press, evalid, ekey, emake, eovf}, 32'd0);
        idle(1);
        reset = 1'b0;
        send(8'hE0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        send(8'h75);
        chk("rst_prefix_drop", {27'd0, held}, 32'h00);
        send(8'hE0); send(8'h75);
        chk("rst_then_up", {27'd0, held}, 32'h01);

        // randomized stream
        for (int i = 0; i < 3000; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0, 1:    pick = 8'hE0;
                2, 3:    pick = 8'hF0;
                4:       pick = 8'h75;
                5:       pick = 8'h6B;
                6:       pick = 8'h74;
                7:       pick = 8'h72;
                8:       pick = 8'h29;
                default: pick = 8'($urandom_range(0, 255));
            endcase
            send(pick);
            if ($urandom_range(0, 40) == 0) begin
                idle($urandom_range(T - 4, T + 3));
            end else begin
                idle($urandom_range(0, 2));
            end
            if ($urandom_range(0, 400) == 0) begin
                reset = 1'b1;
                idle(1);
                reset = 1'b0;
            end
        end

        idle(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
